// File: rtl/seven_seg_scan.sv
// Multiplexed common-anode seven-segment scanner with frame-coherent shadow latching.
// AN/CA/frame_done are registered one cycle behind the slot counter; free-running, no backpressure.
module seven_seg_scan #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   disp_value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  lz_suppress,
    input  logic                  enable,
    output logic [7:0]            AN,
    output logic [7:0]            CA,
    output logic                  frame_done
);
    localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [2:0]    IDX_LAST = 3'(DIGITS - 1);

    typedef enum logic {PH_GUARD, PH_ACTIVE} phase_t;

    logic [CW-1:0]       cnt;
    logic [2:0]          idx;
    logic                cnt_wrap;
    logic                frame_end;
    logic                latch_now;
    logic                in_guard;
    phase_t              phase;

    logic [4*DIGITS-1:0] sh_value;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_blank;
    logic                sh_lz;

    logic [4*DIGITS-1:0] val_cur;
    logic [DIGITS-1:0]   dp_cur;
    logic [DIGITS-1:0]   blank_cur;
    logic                lz_cur;

    logic [31:0]         val8;
    logic [7:0]          dp8;
    logic [7:0]          blank8;
    logic [3:0]          nib [8];
    logic [7:0]          zero_above;
    logic                zero_run;
    logic [6:0]          seg;
    logic [7:0]          an_nxt;
    logic [7:0]          ca_nxt;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h7F;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign cnt_wrap  = (cnt == CNT_LAST);
    assign frame_end = cnt_wrap && (idx == IDX_LAST);
    assign latch_now = (idx == 3'd0) && (cnt == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
            idx <= 3'd0;
        end else if (cnt_wrap) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    generate
        if (GUARD == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            assign in_guard = (cnt < CW'(GUARD));
        end
    endgenerate

    always_comb begin
        phase = PH_ACTIVE;
        if (in_guard) begin
            phase = PH_GUARD;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sh_value <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            sh_lz    <= 1'b0;
        end else if (latch_now) begin
            sh_value <= disp_value;
            sh_dp    <= dp_mask;
            sh_blank <= blank_mask;
            sh_lz    <= lz_suppress;
        end
    end

    // On the latch cycle the incoming frame is decoded directly so digit 0 never shows stale data.
    assign val_cur   = latch_now ? disp_value  : sh_value;
    assign dp_cur    = latch_now ? dp_mask     : sh_dp;
    assign blank_cur = latch_now ? blank_mask  : sh_blank;
    assign lz_cur    = latch_now ? lz_suppress : sh_lz;

    always_comb begin
        val8       = 32'(val_cur);
        dp8        = 8'(dp_cur);
        blank8     = 8'(blank_cur);
        zero_run   = 1'b1;
        zero_above = 8'h00;
        an_nxt     = 8'hFF;
        ca_nxt     = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            nib[i] = val8[4*i +: 4];
        end
        // Padding nibbles above DIGITS are zero, so they never block suppression.
        for (int i = 7; i >= 0; i--) begin
            zero_run      = zero_run & (nib[i] == 4'd0);
            zero_above[i] = zero_run;
        end
        seg = hex_to_seg(nib[idx]);
        if (lz_cur && (idx != 3'd0) && zero_above[idx]) begin
            seg = 7'h7F;
        end
        if ((phase == PH_ACTIVE) && enable && !blank8[idx]) begin
            an_nxt = ~(8'd1 << idx);
            ca_nxt = {~dp8[idx], seg};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            AN         <= 8'hFF;
            CA         <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            AN         <= an_nxt;
            CA         <= ca_nxt;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomised scoreboard bench for seven_seg_scan: a cycle-time reference model predicts every output cycle.
module tb_seven_seg_scan;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 8;
    localparam int GUARD    = 2;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] disp_value = 16'h1234;
    logic [3:0]  dp_mask = 4'b0;
    logic [3:0]  blank_mask = 4'b0;
    logic        lz_suppress = 1'b0;
    logic        enable = 1'b1;
    logic [7:0]  AN;
    logic [7:0]  CA;
    logic        frame_done;

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] ca;
        logic       fd;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [6:0] seg_tab [16];

    seven_seg_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD)) dut (
        .CLK(CLK), .RST(RST), .disp_value(disp_value), .dp_mask(dp_mask),
        .blank_mask(blank_mask), .lz_suppress(lz_suppress), .enable(enable),
        .AN(AN), .CA(CA), .frame_done(frame_done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference model: time since reset release decides slot, digit and frame; values snapshot per frame.
    initial begin : model
        int         t;
        int         slot;
        int         dig;
        logic [1:0] d2;
        logic [15:0] sv;
        logic [3:0] sdp;
        logic [3:0] sbl;
        logic       slz;
        logic [3:0] nib;
        logic [6:0] seg;
        exp_t       e;
        t = 0; sv = '0; sdp = '0; sbl = '0; slz = 1'b0;
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) begin
                exp_q.delete();
                t = 0;
            end else begin
                slot = t % SCAN_DIV;
                dig  = (t / SCAN_DIV) % DIGITS;
                d2   = 2'(dig);
                if (t % FRAME == 0) begin
                    sv = disp_value; sdp = dp_mask; sbl = blank_mask; slz = lz_suppress;
                end
                e.fd = (t % FRAME == FRAME - 1);
                e.an = 8'hFF;
                e.ca = 8'hFF;
                if (enable && slot >= GUARD && !sbl[d2]) begin
                    nib = 4'(sv >> (4 * dig));
                    seg = seg_tab[nib];
                    if (slz && dig > 0 && (sv >> (4 * dig)) == 16'd0) seg = 7'h7F;
                    e.an = ~(8'd1 << dig);
                    e.ca = {~sdp[d2], seg};
                end
                exp_q.push_back(e);
                t++;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST) begin
                check("rst_AN", AN, 8'hFF);
                check("rst_CA", CA, 8'hFF);
                check("rst_frame_done", {7'b0, frame_done}, 8'h00);
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: DUT output with no expectation at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("AN", AN, e.an);
                check("CA", CA, e.ca);
                check("frame_done", {7'b0, frame_done}, {7'b0, e.fd});
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic reset_pulse();
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("async_AN", AN, 8'hFF);
        check("async_CA", CA, 8'hFF);
        check("async_frame_done", {7'b0, frame_done}, 8'h00);
        @(negedge CLK);
        #1 RST = 1'b0;
    endtask

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
        seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;

        #1 RST = 1'b1;
        #1;
        check("init_AN", AN, 8'hFF);
        check("init_CA", CA, 8'hFF);
        check("init_frame_done", {7'b0, frame_done}, 8'h00);
        cycles(3);
        RST = 1'b0;

        // Plain 1234 scan, then a mid-slot reset.
        cycles(21);
        reset_pulse();
        cycles(64);

        // Realign to a fresh frame and change the value during digit 2's slot.
        reset_pulse();
        cycles(18);
        disp_value = 16'hABCD;
        cycles(14 + 64);

        // Leading-zero suppression.
        lz_suppress = 1'b1;
        disp_value  = 16'h0050;
        cycles(64);
        disp_value  = 16'h0000;
        cycles(64);
        lz_suppress = 1'b0;

        // Decimal point and blanking.
        disp_value = 16'h1234;
        dp_mask    = 4'b0010;
        blank_mask = 4'b0100;
        cycles(64);
        dp_mask    = 4'b0;
        blank_mask = 4'b0;

        // Enable dropped for five cycles mid-slot.
        cycles(11);
        enable = 1'b0;
        cycles(5);
        enable = 1'b1;
        cycles(40);

        for (int k = 0; k < 30; k++) begin
            disp_value = 16'($urandom);
            if ($urandom_range(0, 2) == 0) disp_value = disp_value >> (4 * $urandom_range(1, 4));
            lz_suppress = 1'($urandom_range(0, 1));
            dp_mask     = 4'($urandom);
            blank_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            enable      = ($urandom_range(0, 5) != 0);
            cycles($urandom_range(1, 45));
            if ($urandom_range(0, 7) == 0) reset_pulse();
        end

        enable = 1'b1;
        cycles(40);
        check("scoreboard_drain", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
